cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//   Memory-side responder for the 4-bit CPU bus (address[5:0], RW, 4-bit data each way).
//   Holds the 64x4 program/data store, answers CPU fetches combinationally and applies CPU writes.
//   Every CPU write to the result slot (RESULT_ADDR) is also queued in a small result FIFO
//   for the bench or host to drain.
//   A load port fills memory before the CPU runs; cpu_run gates the CPU. Sits between CPU and top level.
// PARAMETERS
//   ADDR_W      6   CPU address width (memory depth = 2**ADDR_W)
//   DATA_W      4   data word width
//   RESULT_ADDR 63  address whose CPU writes are also pushed to the result FIFO
//   RES_DEPTH   4   result FIFO depth (power of 2, >=2)
// PORTS
//   clk          in   1       single clock, all state changes on posedge
//   rst_n        in   1       asynchronous, active-low reset
//   address      in   ADDR_W  CPU address
//   RW           in   1       CPU write strobe, level-sampled on posedge clk (1=write)
//   cpu_wdata    in   DATA_W  CPU write data (CPU data_out)
//   cpu_rdata    out  DATA_W  read data to CPU (CPU data_in)
//   cpu_run      out  1       high while CPU may execute
//   load_valid   in   1       load word offered
//   load_ready   out  1       load word accepted when valid&ready
//   load_addr    in   ADDR_W  load target address
//   load_data    in   DATA_W  load word
//   load_done    in   1       end of load, start CPU
//   halt         in   1       stop CPU, return to load
//   res_valid    out  1       result FIFO non-empty
//   res_data     out  DATA_W  FIFO head (valid only when res_valid)
//   res_ready    in   1       pop head when res_valid&res_ready
//   res_overflow out  1       sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//   Reset: state=LOAD, all mem words=0, FIFO empty, cpu_run=0, load_ready=1 (reflects LOAD),
//     res_valid=0, res_data=0, res_overflow=0, cpu_rdata=0.
//   FSM LOAD -> RUN -> LOAD:
//     LOAD: load_ready=1. valid&ready writes mem[load_addr]<=load_data at the posedge.
//       load_done -> RUN next cycle. A load beat in the same cycle as load_done is still written.
//       RW and address are ignored.
//     RUN: cpu_run=1, load_ready=0. load_valid is ignored.
//       halt -> LOAD next cycle. halt has priority over a same-cycle CPU write: that write is dropped.
//   Read: in RUN, cpu_rdata = mem[address] combinationally (zero latency). Outside RUN it is 0.
//     Same-cycle read of a word being written returns the OLD value.
//   CPU write (RUN, RW=1 at posedge): mem[address]<=cpu_wdata.
//     If address==RESULT_ADDR, cpu_wdata is also pushed to the FIFO.
//   FIFO: circular buffer with wrapping rd/wr pointers and count of $clog2(RES_DEPTH+1) bits.
//     Full and push without pop: word dropped, res_overflow<=1 (sticky to reset); mem still written.
//     Full with push and pop in the same cycle: both occur, count unchanged, no overflow.
//     Empty with push (and res_ready): push only; res_valid rises the next cycle (no bypass).
//     FIFO contents and res_overflow survive LOAD/RUN transitions. Only rst_n clears them.
//   Reset mid-load or mid-run clears everything immediately (async); no partial write completes.
// STRUCTURE
//   Package cpu_mem_pkg: state enum {LOAD, RUN}, ADDR_W/DATA_W/RESULT_ADDR defaults.
//   Sub-module result_fifo (DATA_W, RES_DEPTH): push/pop/full/empty/overflow. Top holds FSM + array.
// TESTING
//   1 Reset, load mem[0..3]=1,5,3,2, load_done
//       -> cpu_run=1 after 1 cycle; address=1 gives cpu_rdata=5 same cycle.
//   2 RUN, RW=1 addr=63 data=8
//       -> mem[63]=8, next cycle res_valid=1, res_data=8; pop -> res_valid=0.
//   3 Five writes to 63 (values 1..5), no pops, RES_DEPTH=4
//       -> FIFO holds 1,2,3,4; res_overflow=1; mem[63]=5.
//   4 FIFO full, write 9 to 63 with res_ready=1
//       -> head 1 popped, 9 queued, overflow stays 0 (fresh reset).
//   5 RUN, halt with RW=1 addr=10 data=7
//       -> mem[10] unchanged, cpu_run=0 next cycle, load_ready=1, cpu_rdata=0.
//   6 rst_n low mid-RUN with FIFO non-empty
//       -> cpu_run=0, res_valid=0, mem[0]=0 immediately, no clock needed.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the CPU memory responder.
package cpu_mem_pkg;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 4;
  localparam int RESULT_ADDR = 63;
  localparam int RES_DEPTH   = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/result_fifo.sv
// Small circular result queue; a push into a full queue is dropped unless a pop frees a slot
// in the same cycle, and drops raise a sticky overflow flag.
module result_fifo #(
  parameter int DATA_W    = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic              overflow
);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  logic [DATA_W-1:0] store [RES_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(RES_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : store[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory side of the 4-bit CPU bus: program/data store, load port, run/halt control,
// and capture of result-slot writes into a drainable queue.
//   state | meaning
//   LOAD  | host fills memory through the load port, CPU held off
//   RUN   | CPU fetches/writes memory, load port closed
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W      = cpu_mem_pkg::DATA_W,
  parameter int RESULT_ADDR = cpu_mem_pkg::RESULT_ADDR,
  parameter int RES_DEPTH   = cpu_mem_pkg::RES_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              RW,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              halt,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              res_overflow
);
  localparam int MEM_D = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] RES_A = ADDR_W'(RESULT_ADDR);

  state_e            state;
  logic [DATA_W-1:0] mem [MEM_D];
  logic              load_we;
  logic              cpu_we;
  logic              res_push;
  logic              res_empty;
  logic              res_full;

  assign load_we  = (state == LOAD) & load_valid;
  // halt wins over a same-cycle CPU write
  assign cpu_we   = (state == RUN) & RW & ~halt;
  assign res_push = cpu_we & (address == RES_A);

  assign cpu_rdata = (state == RUN) ? mem[address] : '0;
  assign res_valid = ~res_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      cpu_run    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        LOAD: if (load_done) begin
          state      <= RUN;
          cpu_run    <= 1'b1;
          load_ready <= 1'b0;
        end
        RUN: if (halt) begin
          state      <= LOAD;
          cpu_run    <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= LOAD;
          cpu_run    <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_D; i++) mem[i] <= '0;
    end else if (load_we) begin
      mem[load_addr] <= load_data;
    end else if (cpu_we) begin
      mem[address] <= cpu_wdata;
    end
  end

  result_fifo #(
    .DATA_W    (DATA_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (res_push),
    .push_data (cpu_wdata),
    .pop       (res_ready),
    .full      (res_full),
    .empty     (res_empty),
    .head      (res_data),
    .overflow  (res_overflow)
  );
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed scenarios with literal expectations plus a random
// run compared every cycle against a queue/array reference model.
module tb_cpu_mem_responder;
  logic       clk;
  logic       rst_n;
  logic [5:0] address;
  logic       RW;
  logic [3:0] cpu_wdata;
  logic [3:0] cpu_rdata;
  logic       cpu_run;
  logic       load_valid;
  logic       load_ready;
  logic [5:0] load_addr;
  logic [3:0] load_data;
  logic       load_done;
  logic       halt;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ready;
  logic       res_overflow;

  int checks;
  int failures;
  bit chk_en;

  logic [3:0] m_mem [64];
  logic [3:0] m_q [$];
  bit         m_run;
  bit         m_ovf;

  cpu_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .RW           (RW),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_run      (cpu_run),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_done    (load_done),
    .halt         (halt),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .res_overflow (res_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 4'd0;
    m_q.delete();
    m_run = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Reference model: one update per clock from the inputs held across the edge.
  always @(posedge clk) begin
    if (rst_n) begin
      bit pop_now;
      bit push_now;
      pop_now  = res_ready && (m_q.size() > 0);
      push_now = 1'b0;
      if (m_run) begin
        if (halt) m_run = 1'b0;
        else if (RW) begin
          m_mem[address] = cpu_wdata;
          push_now = (address == 6'd63);
        end
      end else begin
        if (load_valid) m_mem[load_addr] = load_data;
        if (load_done) m_run = 1'b1;
      end
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        if (m_q.size() < 4) m_q.push_back(cpu_wdata);
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison, sampled well after the edge.
  always @(posedge clk) begin
    #2;
    if (chk_en && rst_n) begin
      chk("cmp_cpu_run", int'(cpu_run), int'(m_run));
      chk("cmp_load_ready", int'(load_ready), int'(!m_run));
      chk("cmp_res_valid", int'(res_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) chk("cmp_res_data", int'(res_data), int'(m_q[0]));
      chk("cmp_res_overflow", int'(res_overflow), int'(m_ovf));
      chk("cmp_cpu_rdata", int'(cpu_rdata), m_run ? int'(m_mem[address]) : 0);
    end
  end

  task automatic idle_inputs();
    address = '0; RW = 0; cpu_wdata = '0;
    load_valid = 0; load_addr = '0; load_data = '0; load_done = 0;
    halt = 0; res_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 0;
    idle_inputs();
    rst_n = 0;
    model_reset();
    #2;
    rst_n = 1;
    chk_en = 1;
  endtask

  task automatic go_run();
    load_done = 1;
    @(negedge clk);
    load_done = 0;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [3:0] d, input bit rdy);
    address = a; RW = 1; cpu_wdata = d; res_ready = rdy;
    @(negedge clk);
    RW = 0; res_ready = 0;
  endtask

  initial begin
    logic [3:0] init_vals [4];
    checks = 0;
    failures = 0;
    chk_en = 0;
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cpu_run", int'(cpu_run), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_overflow", int'(res_overflow), 0);
    chk("rst_cpu_rdata", int'(cpu_rdata), 0);
    rst_n = 1;
    chk_en = 1;

    // 1: load 1,5,3,2 then start
    init_vals = '{4'd1, 4'd5, 4'd3, 4'd2};
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_addr = 6'(i); load_data = init_vals[i];
      @(negedge clk);
    end
    load_valid = 0;
    go_run();
    address = 6'd1;
    #1;
    chk("t1_cpu_run", int'(cpu_run), 1);
    chk("t1_rdata_addr1", int'(cpu_rdata), 5);

    // 2: single result write then pop
    cpu_write(6'd63, 4'd8, 1'b0);
    #1;
    chk("t2_res_valid", int'(res_valid), 1);
    chk("t2_res_data", int'(res_data), 8);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    address = 6'd63;
    #1;
    chk("t2_res_valid_after_pop", int'(res_valid), 0);
    chk("t2_mem63", int'(cpu_rdata), 8);

    // 3: five result writes, no pops
    for (int v = 1; v <= 5; v++) cpu_write(6'd63, 4'(v), 1'b0);
    address = 6'd63;
    #1;
    chk("t3_overflow", int'(res_overflow), 1);
    chk("t3_mem63", int'(cpu_rdata), 5);
    for (int v = 1; v <= 4; v++) begin
      chk("t3_drain", int'(res_data), v);
      res_ready = 1;
      @(negedge clk);
      #1;
    end
    res_ready = 0;
    chk("t3_empty", int'(res_valid), 0);

    // 4: full FIFO, push and pop in the same cycle
    do_reset();
    go_run();
    for (int v = 1; v <= 4; v++) cpu_write(6'd63, 4'(v), 1'b0);
    cpu_write(6'd63, 4'd9, 1'b1);
    #1;
    chk("t4_overflow", int'(res_overflow), 0);
    chk("t4_head", int'(res_data), 2);
    init_vals = '{4'd2, 4'd3, 4'd4, 4'd9};
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", int'(res_data), int'(init_vals[i]));
      res_ready = 1;
      @(negedge clk);
      #1;
    end
    res_ready = 0;
    chk("t4_empty", int'(res_valid), 0);

    // 5: halt beats a same-cycle write
    address = 6'd10; RW = 1; cpu_wdata = 4'd7; halt = 1;
    @(negedge clk);
    RW = 0; halt = 0;
    #1;
    chk("t5_cpu_run", int'(cpu_run), 0);
    chk("t5_load_ready", int'(load_ready), 1);
    chk("t5_rdata", int'(cpu_rdata), 0);
    load_valid = 1; load_addr = 6'd0; load_data = 4'd6;
    @(negedge clk);
    load_valid = 0;
    go_run();
    address = 6'd10;
    #1;
    chk("t5_mem10", int'(cpu_rdata), 0);
    address = 6'd0;
    #1;
    chk("t5_mem0", int'(cpu_rdata), 6);

    // 6: async reset mid-run with a queued result
    cpu_write(6'd63, 4'd3, 1'b0);
    #1;
    chk("t6_res_valid_pre", int'(res_valid), 1);
    chk_en = 0;
    #1;
    rst_n = 0;
    model_reset();
    #1;
    chk("t6_cpu_run", int'(cpu_run), 0);
    chk("t6_res_valid", int'(res_valid), 0);
    chk("t6_load_ready", int'(load_ready), 1);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    chk_en = 1;
    go_run();
    address = 6'd0;
    #1;
    chk("t6_mem0", int'(cpu_rdata), 0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      load_valid = ($urandom_range(1, 0) == 1);
      load_addr  = 6'($urandom_range(63, 0));
      load_data  = 4'($urandom_range(15, 0));
      load_done  = ($urandom_range(19, 0) == 0);
      halt       = ($urandom_range(29, 0) == 0);
      RW         = ($urandom_range(9, 0) < 4);
      address    = ($urandom_range(3, 0) == 0) ? 6'd63 : 6'($urandom_range(63, 0));
      cpu_wdata  = 4'($urandom_range(15, 0));
      res_ready  = ($urandom_range(9, 0) < 3);
      if (n == 1500) begin
        #2;
        chk_en = 0;
        rst_n = 0;
        model_reset();
        #1;
        rst_n = 1;
        chk_en = 1;
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
